// File: rtl/vec_read_accum.sv
// Pipelined Avalon-MM read master that fetches a vector of signed elements and
// reduces them to a single sum, sum-of-magnitudes or maximum.
//
//  state | meaning
//  IDLE  | waiting for start; inputs captured and accumulator seeded on start
//  ISSUE | presenting reads while elements remain and a return slot is free
//  DRAIN | all reads accepted; waiting for the remaining returns
//  FIN   | one-cycle done pulse, result valid
module vec_read_accum #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int RESULT_W  = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_ptr,
    input  logic [31:0]         size,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest,
    input  logic                readdatavalid
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0]   STRIDE   = ADDR_W'(DATA_W / 8);
    localparam logic [OUT_W-1:0]    OUT_MAX  = OUT_W'(MAX_OUTST);
    localparam logic [DATA_W-1:0]   MIN_ELEM = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [31:0]                 size_q, size_d;
    logic [1:0]                  mode_q, mode_d;
    logic [31:0]                 issued_q, issued_d;
    logic [31:0]                 returned_q, returned_d;
    logic [OUT_W-1:0]            outst_q, outst_d;
    logic signed [RESULT_W-1:0]  acc_q, acc_d;
    logic [RESULT_W-1:0]         result_q, result_d;

    logic                        accept;
    logic                        ret_ok;
    logic signed [RESULT_W-1:0]  elem;
    logic signed [RESULT_W-1:0]  elem_abs;
    logic signed [RESULT_W-1:0]  max_ident;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        mode_d     = mode_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        outst_d    = outst_q;
        acc_d      = acc_q;
        result_d   = result_q;
        busy       = 1'b0;
        done       = 1'b0;

        // read depends only on registered state, so it cannot move while stalled
        read      = (state_q == ISSUE) && (issued_q < size_q) && (outst_q < OUT_MAX);
        accept    = read && !waitrequest;
        ret_ok    = readdatavalid && (outst_q != '0) && (returned_q != size_q);
        elem      = RESULT_W'($signed(readdata));
        elem_abs  = elem[RESULT_W-1] ? -elem : elem;
        max_ident = RESULT_W'($signed(MIN_ELEM));

        if (accept) begin
            issued_d = issued_q + 32'd1;
            addr_d   = addr_q + STRIDE;
        end

        if (ret_ok) begin
            returned_d = returned_q + 32'd1;
            case (mode_q)
                2'd1:    acc_d = acc_q + elem_abs;
                2'd2:    acc_d = (elem > acc_q) ? elem : acc_q;
                default: acc_d = acc_q + elem;
            endcase
        end

        case ({accept, ret_ok})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = base_ptr;
                    size_d     = size;
                    mode_d     = mode;
                    issued_d   = '0;
                    returned_d = '0;
                    acc_d      = (mode == 2'd2) ? max_ident : '0;
                    // an empty vector passes through DRAIN, which exits at once
                    state_d    = (size == 32'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (issued_q == size_q) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (returned_q == size_q) begin
                    state_d  = FIN;
                    result_d = acc_q;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            mode_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            outst_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            mode_q     <= mode_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            outst_q    <= outst_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    assign address = addr_q;
    assign result  = result_q;

    // a return with nothing in flight points at a broken interconnect
    assert property (@(posedge clk) disable iff (!reset)
        readdatavalid |-> ((outst_q != '0) && (returned_q != size_q)));

endmodule
